// File: rtl/bus_transfer_scheduler.sv
// rtl/bus_transfer_scheduler.sv - round-robin arbiter and transfer sequencer for the common bus
// Grants one requester at a time, drives bus selects, settles, pulses load, then acknowledges.
module bus_transfer_scheduler #(
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] req,
   input  logic [7:0] dst,
   output logic       s0,
   output logic       s1,
   output logic [3:0] grant,
   output logic [3:0] ld,
   output logic [3:0] ack,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, DRIVE, LOAD, ACK} state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic [1:0] src, src_nx;
   logic [1:0] dsel, dsel_nx;
   logic [1:0] ptr, ptr_nx;
   logic [1:0] sel, sel_nx;
   logic [1:0] arb_idx;
   logic [1:0] win;
   logic       win_vld;
   logic [3:0] grant_nx, ld_nx, ack_nx;
   logic       busy_nx;

   // Scan from the farthest offset down so the nearest set bit above ptr wins.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      arb_idx = '0;
      for (int i = 3; i >= 0; i--) begin
         arb_idx = ptr + 2'(i);
         if (req[arb_idx]) begin
            win     = arb_idx;
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      src_nx   = src;
      dsel_nx  = dsel;
      ptr_nx   = ptr;
      sel_nx   = sel;
      case (state)
         IDLE: begin
            if (win_vld) begin
               src_nx   = win;
               dsel_nx  = dst[int'(win) * 2 +: 2];
               sel_nx   = win;
               cnt_nx   = CNT_INIT;
               state_nx = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt == 4'd0) state_nx = LOAD;
            else             cnt_nx   = cnt - 4'd1;
         end
         LOAD: state_nx = ACK;
         ACK: begin
            ptr_nx   = src + 2'd1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      // Outputs are registered, so they are computed from the upcoming state.
      grant_nx = '0;
      ld_nx    = '0;
      ack_nx   = '0;
      if (state_nx == DRIVE || state_nx == LOAD) grant_nx = 4'b0001 << src_nx;
      if (state_nx == LOAD)                      ld_nx    = 4'b0001 << dsel_nx;
      if (state_nx == ACK)                       ack_nx   = 4'b0001 << src_nx;
      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= IDLE;
         cnt   <= '0;
         src   <= '0;
         dsel  <= '0;
         ptr   <= '0;
         sel   <= '0;
         grant <= '0;
         ld    <= '0;
         ack   <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         src   <= src_nx;
         dsel  <= dsel_nx;
         ptr   <= ptr_nx;
         sel   <= sel_nx;
         grant <= grant_nx;
         ld    <= ld_nx;
         ack   <= ack_nx;
         busy  <= busy_nx;
      end
   end

   assign s1 = sel[1];
   assign s0 = sel[0];

endmodule

// File: doc/bus_transfer_scheduler.md
# bus_transfer_scheduler

Round-robin arbiter and transfer sequencer for the 4-register common bus. Four requesters each ask to copy their source register onto the bus and into a chosen destination register. The block grants one requester at a time and drives the bus-mux selects `{s1,s0}`. It holds the bus stable for a programmable settle time, pulses the destination load enable, then acknowledges the requester. It sits beside the register file and the four Mux4 slices and is their only source of select and load controls.

## Interface
- `SETTLE`, default 1: number of cycles the bus is driven before the load pulse. Legal range 1..15; the counter is 4 bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `req` in 4: `req[i]` requests transfer of register i (source index i) onto the bus.
- `dst` in 8: `dst[2i+1:2i]` is the destination register index for requester i. Sampled only at grant.
- `s0` out 1: bus-mux select LSB. Source index = `{s1,s0}`; 0 selects a, 3 selects d.
- `s1` out 1: bus-mux select MSB.
- `grant` out 4: one-hot; granted requester, high throughout DRIVE and LOAD.
- `ld` out 4: one-hot destination load enable, high only in LOAD.
- `ack` out 4: one-cycle completion pulse to the granted requester.
- `busy` out 1: high in DRIVE, LOAD and ACK.

## Operation
- All outputs are registered.
- FSM states: IDLE, DRIVE, LOAD, ACK.
- **IDLE**
  - If `req` is nonzero, the winner is the first set bit searching upward (mod 4) from the priority pointer `ptr`.
  - Capture `src` = winner and `dsel` = its `dst` field.
  - Load `{s1,s0}` = winner and `cnt` = SETTLE−1, then go to DRIVE.
  - If `req` is zero, stay in IDLE.
- **DRIVE**
  - `grant[src]` = 1.
  - If `cnt` == 0, go to LOAD; otherwise decrement `cnt`.
- **LOAD**
  - `grant[src]` = 1 and `ld[dsel]` = 1 for exactly one cycle.
  - Go to ACK.
- **ACK**
  - `ack[src]` = 1 for one cycle; `grant` = 0.
  - Set `ptr` = (`src`+1) mod 4, then go to IDLE.
  - No arbitration happens in ACK.
- Selects `{s1,s0}` hold the last source through IDLE, so the bus is stable between transfers. They change only on the IDLE→DRIVE edge.
- `req` is sampled only in IDLE. Dropping `req[src]` mid-transfer does not abort; the transfer completes and `ack` still pulses.
- A requester deasserts `req` on the cycle it sees `ack`. If `req` is still high in the following IDLE, it is a new request, arbitrated against the rotated pointer.
- `dst` == `src` is legal: `ld[src]` pulses and the register reloads its own value.
- Several destinations are never loaded at once; `ld` is always one-hot or zero.
- Reset values:
  - `s0`=0, `s1`=0
  - `grant`=0, `ld`=0, `ack`=0, `busy`=0
  - `ptr`=0, so requester 0 has highest priority
  - state = IDLE, `cnt`=0
- `clr` at any edge, including mid-DRIVE or LOAD:
  - Forces the reset values on the next edge.
  - Any pending `ld` or `ack` pulse is suppressed.
  - The interrupted transfer is never acknowledged.
- `clr` has priority over every other input.

## Timing
- With `req[i]` high at rising edge k in IDLE:
  - DRIVE from edge k to k+SETTLE (SETTLE cycles).
  - LOAD in the cycle after edge k+SETTLE.
  - ACK in the cycle after edge k+SETTLE+1.
  - Back in IDLE after edge k+SETTLE+2.
- Transfer occupancy is SETTLE+3 cycles including the arbitration cycle. With SETTLE=1 this is 4 cycles per transfer, and back-to-back requests are served one every 4 cycles.
- The register file captures on the load pulse, so the `ld` rise comes at least SETTLE cycles after the select change.
- Fairness: with all four `req` held high, grants rotate 0,1,2,3,0… Worst-case wait is 3 transfers.

## Test plan
- **Reset:** hold `clr`=1 for 2 cycles with `req`=4'b1111.
  - All outputs 0.
  - First grant after release is requester 0.
- **Single transfer, SETTLE=1:** `req`=4'b0100, `dst[5:4]`=2'd1, one edge in IDLE.
  - `{s1,s0}`=2, `grant`=4'b0100 for 2 cycles.
  - `ld`=4'b0010 in the 2nd of those cycles.
  - `ack`=4'b0100 the next cycle, then IDLE.
- **Round-robin:** `req`=4'b1111 held continuously.
  - `ack` order 0,1,2,3,0, spaced 4 cycles apart.
  - `ptr` wraps from 3 to 0.
- **Settle parameter:** SETTLE=3, `req[1]` pulsed one cycle only.
  - DRIVE lasts 3 cycles with `grant`=4'b0010.
  - `ld` fires once and `ack[1]` fires once, even though `req` dropped.
- **Reset mid-operation:** assert `clr` in the LOAD cycle of a transfer.
  - No `ack` pulse.
  - Next edge shows all outputs 0.
  - A subsequent `req[3]` is granted normally.
- **Self-copy and select hold:** `req[2]` with `dst[5:4]`=2.
  - `ld`=4'b0100.
  - After ACK, `{s1,s0}` stays 2 in IDLE until the next grant.
